param_regfile: RTL and testbench

Parametrised register file for the puzzle-solver datapath, replacing the fixed 64x5 register bank. It provides configurable depth and width, three combinational read ports and two write ports with fixed priority, plus optional write-to-read bypass. A multi-cycle range-clear engine lets the controller wipe the path/board regions between search iterations without a global reset. Dedicated status taps expose the packed move history, the move counter and the completion flag.

---
 rtl/param_regfile.sv | 160 ++++++++++++++++
 tb/tb_param_regfile.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_regfile.sv
// Parametrised multi-port register file with a priority write path, optional
// write-to-read bypass, a multi-cycle range-clear engine and status taps.
module param_regfile #(
    parameter int DEPTH     = 64,
    parameter int AW        = 6,
    parameter int DW        = 5,
    parameter int BYPASS    = 1,
    parameter int PACK_BASE = 31,
    parameter int PACK_CNT  = 32,
    parameter int PACK_BITS = 2,
    parameter int CNT_ADDR  = 27,
    parameter int COMP_ADDR = 63
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          we0,
    input  logic [AW-1:0]                 waddr0,
    input  logic [DW-1:0]                 wdata0,
    input  logic                          we1,
    input  logic [AW-1:0]                 waddr1,
    input  logic [DW-1:0]                 wdata1,
    input  logic [AW-1:0]                 raddr0,
    input  logic [AW-1:0]                 raddr1,
    input  logic [AW-1:0]                 raddr2,
    output logic [DW-1:0]                 rdata0,
    output logic [DW-1:0]                 rdata1,
    output logic [DW-1:0]                 rdata2,
    input  logic                          clr_req,
    input  logic [AW-1:0]                 clr_base,
    input  logic [AW:0]                   clr_len,
    output logic                          clr_busy,
    output logic                          clr_done,
    output logic [PACK_CNT*PACK_BITS-1:0] packed_out,
    output logic [63:0]                   cnt_out,
    output logic                          comp
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state_reg, state_next;
    logic [AW-1:0] ptr_reg, ptr_next;
    logic [AW:0]   rem_reg, rem_next;
    logic [AW:0]   len_sat;
    logic          clr_we;

    logic [DW-1:0] mem_reg [DEPTH];

    // Oversized lengths would otherwise revisit entries after wrapping.
    assign len_sat = (clr_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : clr_len;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
            rem_reg   <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            rem_reg   <= rem_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        rem_next   = rem_reg;
        clr_we     = 1'b0;
        clr_busy   = 1'b0;
        clr_done   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (clr_req) begin
                    if (len_sat != '0) begin
                        ptr_next   = clr_base;
                        rem_next   = len_sat;
                        state_next = CLEAR;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            CLEAR: begin
                clr_we   = 1'b1;
                clr_busy = 1'b1;
                ptr_next = ptr_reg + 1'b1;
                rem_next = rem_reg - 1'b1;
                if (rem_reg == (AW+1)'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                clr_done   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Per-entry write mux: clear engine, then port 0, then port 1.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            localparam logic [AW-1:0] IDX = AW'(gi);
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    mem_reg[gi] <= '0;
                end else if (clr_we && (ptr_reg == IDX)) begin
                    mem_reg[gi] <= '0;
                end else if (we0 && (waddr0 == IDX)) begin
                    mem_reg[gi] <= wdata0;
                end else if (we1 && (waddr1 == IDX)) begin
                    mem_reg[gi] <= wdata1;
                end
            end
        end
    endgenerate

    logic [AW-1:0] raddr_arr [3];
    logic [DW-1:0] rdata_arr [3];

    assign raddr_arr[0] = raddr0;
    assign raddr_arr[1] = raddr1;
    assign raddr_arr[2] = raddr2;
    assign rdata0       = rdata_arr[0];
    assign rdata1       = rdata_arr[1];
    assign rdata2       = rdata_arr[2];

    generate
        for (gi = 0; gi < 3; gi++) begin : g_rport
            always_comb begin
                rdata_arr[gi] = mem_reg[raddr_arr[gi]];
                if (BYPASS != 0) begin
                    if (clr_we && (ptr_reg == raddr_arr[gi])) begin
                        rdata_arr[gi] = '0;
                    end else if (we0 && (waddr0 == raddr_arr[gi])) begin
                        rdata_arr[gi] = wdata0;
                    end else if (we1 && (waddr1 == raddr_arr[gi])) begin
                        rdata_arr[gi] = wdata1;
                    end
                end
            end
        end
    endgenerate

    // Taps always show stored state, never the bypassed value.
    generate
        for (gi = 0; gi < PACK_CNT; gi++) begin : g_pack
            assign packed_out[gi*PACK_BITS +: PACK_BITS] =
                mem_reg[(PACK_BASE + gi) % DEPTH][PACK_BITS-1:0];
        end
    endgenerate

    assign cnt_out = 64'(mem_reg[CNT_ADDR]);
    assign comp    = mem_reg[COMP_ADDR][0];

endmodule

// File: tb/tb_param_regfile.sv
// Randomised self-checking bench for param_regfile against an array/queue
// reference model, with directed cases for priority, taps and range clear.
module tb_param_regfile;

    localparam int DEPTH = 64;
    localparam int AW    = 6;
    localparam int DW    = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          we0, we1;
    logic [AW-1:0] waddr0, waddr1;
    logic [DW-1:0] wdata0, wdata1;
    logic [AW-1:0] raddr0, raddr1, raddr2;
    logic [DW-1:0] rdata0, rdata1, rdata2;
    logic          clr_req;
    logic [AW-1:0] clr_base;
    logic [AW:0]   clr_len;
    logic          clr_busy, clr_done;
    logic [63:0]   packed_out;
    logic [63:0]   cnt_out;
    logic          comp;

    param_regfile #(
        .DEPTH(64), .AW(6), .DW(5), .BYPASS(1), .PACK_BASE(31), .PACK_CNT(32),
        .PACK_BITS(2), .CNT_ADDR(27), .COMP_ADDR(63)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr0(raddr0), .raddr1(raddr1), .raddr2(raddr2),
        .rdata0(rdata0), .rdata1(rdata1), .rdata2(rdata2),
        .clr_req(clr_req), .clr_base(clr_base), .clr_len(clr_len),
        .clr_busy(clr_busy), .clr_done(clr_done),
        .packed_out(packed_out), .cnt_out(cnt_out), .comp(comp)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: stored contents, addresses still to be cleared, done flag.
    logic [DW-1:0] model [DEPTH];
    logic [AW-1:0] clr_q [$];
    bit            done_now;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        clr_q.delete();
        done_now = 1'b0;
    endfunction

    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
        if (clr_q.size() > 0 && clr_q[0] == a) return '0;
        if (we0 && waddr0 == a) return wdata0;
        if (we1 && waddr1 == a) return wdata1;
        return model[a];
    endfunction

    function automatic logic [63:0] exp_packed();
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) r[i*2 +: 2] = model[31+i][1:0];
        return r;
    endfunction

    task automatic check_outputs();
        check("rdata0", 64'(rdata0), 64'(exp_rd(raddr0)));
        check("rdata1", 64'(rdata1), 64'(exp_rd(raddr1)));
        check("rdata2", 64'(rdata2), 64'(exp_rd(raddr2)));
        check("clr_busy", 64'(clr_busy), 64'(clr_q.size() != 0));
        check("clr_done", 64'(clr_done), 64'(done_now));
        check("packed_out", packed_out, exp_packed());
        check("cnt_out", cnt_out, 64'(model[27]));
        check("comp", 64'(comp), 64'(model[63][0]));
    endtask

    // Advance the model by one rising edge using the inputs held this cycle.
    task automatic model_edge();
        bit            nd;
        bit            cw;
        logic [AW-1:0] ca;
        int            n;
        nd = 1'b0;
        cw = 1'b0;
        ca = '0;
        if (clr_q.size() > 0) begin
            ca = clr_q.pop_front();
            cw = 1'b1;
            if (clr_q.size() == 0) nd = 1'b1;
        end else if (!done_now && clr_req) begin
            n = (int'(clr_len) > DEPTH) ? DEPTH : int'(clr_len);
            if (n == 0) nd = 1'b1;
            for (int k = 0; k < n; k++) clr_q.push_back(AW'(int'(clr_base) + k));
        end
        if (we1) model[waddr1] = wdata1;
        if (we0) model[waddr0] = wdata0;
        if (cw)  model[ca] = '0;
        done_now = nd;
    endtask

    task automatic tick();
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic cycle();
        #3;
        tick();
    endtask

    task automatic idle();
        we0 = 1'b0;
        we1 = 1'b0;
        clr_req = 1'b0;
    endtask

    function automatic logic [AW-1:0] rnd_addr();
        if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, 7));
        return AW'($urandom_range(0, DEPTH-1));
    endfunction

    int busy_cnt, done_cnt;

    initial begin
        idle();
        waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0;
        raddr0 = '0; raddr1 = '0; raddr2 = '0;
        clr_base = '0; clr_len = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle();
        $display("reset state checked");

        // Write then asynchronous reset between edges.
        we0 = 1'b1; waddr0 = 6'd9; wdata0 = 5'h1F; raddr0 = 6'd9;
        cycle();
        idle();
        #3;
        check("t1_read", 64'(rdata0), 64'h1F);
        rst_n = 1'b0;
        #1;
        check("t1_arst_rdata", 64'(rdata0), 64'h0);
        model_reset();
        #1;
        rst_n = 1'b1;
        tick();
        $display("write/async reset transaction done");

        // Same-address write collision: port 0 wins.
        we0 = 1'b1; waddr0 = 6'd4; wdata0 = 5'd3;
        we1 = 1'b1; waddr1 = 6'd4; wdata1 = 5'd7;
        raddr1 = 6'd4;
        #3;
        check("t2_bypass", 64'(rdata1), 64'd3);
        tick();
        idle();
        #3;
        check("t2_stored", 64'(rdata1), 64'd3);
        tick();
        $display("write collision transaction done");

        // Status taps.
        for (int i = 31; i <= 61; i += 2) begin
            we0 = 1'b1; waddr0 = AW'(i);     wdata0 = 5'd1;
            we1 = 1'b1; waddr1 = AW'(i + 1); wdata1 = 5'd1;
            cycle();
        end
        we0 = 1'b1; waddr0 = 6'd27; wdata0 = 5'd12;
        we1 = 1'b1; waddr1 = 6'd63; wdata1 = 5'd1;
        cycle();
        idle();
        #3;
        check("t3_packed", packed_out, 64'h5555_5555_5555_5555);
        check("t3_cnt", cnt_out, 64'd12);
        check("t3_comp", 64'(comp), 64'd1);
        tick();
        $display("tap transaction done");

        // Wrapping range clear with an ignored second request.
        for (int i = 0; i < DEPTH; i += 2) begin
            we0 = 1'b1; waddr0 = AW'(i);     wdata0 = 5'h1F;
            we1 = 1'b1; waddr1 = AW'(i + 1); wdata1 = 5'h1F;
            cycle();
        end
        idle();
        clr_req = 1'b1; clr_base = 6'd62; clr_len = 7'd4;
        cycle();
        busy_cnt = 0;
        done_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            if (k == 1) begin
                clr_req = 1'b1; clr_base = 6'd10; clr_len = 7'd3;
            end else begin
                clr_req = 1'b0;
            end
            #3;
            busy_cnt += int'(clr_busy);
            done_cnt += int'(clr_done);
            tick();
        end
        idle();
        check("t4_busy_cycles", 64'(busy_cnt), 64'd4);
        check("t4_done_pulses", 64'(done_cnt), 64'd1);
        raddr0 = 6'd62; raddr1 = 6'd0; raddr2 = 6'd2;
        #3;
        check("t4_e62", 64'(rdata0), 64'h0);
        check("t4_e0", 64'(rdata1), 64'h0);
        check("t4_e2", 64'(rdata2), 64'h1F);
        tick();
        raddr0 = 6'd63; raddr1 = 6'd1; raddr2 = 6'd10;
        #3;
        check("t4_e63", 64'(rdata0), 64'h0);
        check("t4_e1", 64'(rdata1), 64'h0);
        check("t4_e10", 64'(rdata2), 64'h1F);
        tick();
        $display("range clear transaction done");

        // External writes during a clear.
        clr_req = 1'b1; clr_base = 6'd20; clr_len = 7'd3;
        cycle();
        idle();
        we0 = 1'b1; waddr0 = 6'd20; wdata0 = 5'd9; raddr0 = 6'd20;
        #3;
        check("t5_clr_bypass", 64'(rdata0), 64'h0);
        tick();
        we0 = 1'b1; waddr0 = 6'd40; wdata0 = 5'd9;
        cycle();
        idle();
        repeat (3) cycle();
        raddr0 = 6'd20; raddr1 = 6'd40;
        #3;
        check("t5_cleared", 64'(rdata0), 64'h0);
        check("t5_kept", 64'(rdata1), 64'd9);
        tick();
        $display("clear vs write transaction done");

        // Zero-length clear.
        clr_req = 1'b1; clr_base = 6'd5; clr_len = 7'd0;
        #3;
        check("t6_busy_req", 64'(clr_busy), 64'd0);
        tick();
        idle();
        raddr0 = 6'd5;
        #3;
        check("t6_done", 64'(clr_done), 64'd1);
        check("t6_busy", 64'(clr_busy), 64'd0);
        check("t6_entry", 64'(rdata0), 64'h1F);
        tick();
        #3;
        check("t6_done_once", 64'(clr_done), 64'd0);
        tick();
        $display("zero-length clear transaction done");

        // Reset in the middle of a clear.
        clr_req = 1'b1; clr_base = 6'd0; clr_len = 7'd10;
        cycle();
        idle();
        cycle();
        cycle();
        #3;
        rst_n = 1'b0;
        #1;
        check("t7_busy", 64'(clr_busy), 64'd0);
        check("t7_done", 64'(clr_done), 64'd0);
        check("t7_cnt", cnt_out, 64'd0);
        model_reset();
        #1;
        rst_n = 1'b1;
        tick();
        repeat (12) cycle();
        $display("reset mid-clear transaction done");

        // Random traffic.
        for (int t = 0; t < 3000; t++) begin
            we0 = ($urandom_range(0, 1) == 1);
            we1 = ($urandom_range(0, 1) == 1);
            waddr0 = rnd_addr(); waddr1 = rnd_addr();
            wdata0 = DW'($urandom); wdata1 = DW'($urandom);
            raddr0 = rnd_addr(); raddr1 = rnd_addr(); raddr2 = rnd_addr();
            clr_req = ($urandom_range(0, 15) == 0);
            clr_base = AW'($urandom);
            clr_len = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127))
                                                  : 7'($urandom_range(0, 8));
            cycle();
        end
        idle();
        $display("random traffic transaction done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
